// File: rtl/dsp_mac_pipe.sv
// Four-stage pipelined multiply-accumulate slice: pre-adder, multiplier and post-adder,
// with NCH time-interleaved accumulators and optional saturation on the result.
module dsp_mac_pipe #(
    parameter  int AW  = 18,
    parameter  int BW  = 18,
    parameter  int PW  = 48,
    parameter  int NCH = 4,
    parameter  int SAT = 1,
    localparam int CW  = $clog2(NCH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CE,
    input  logic          CLR,
    input  logic          IN_VALID,
    input  logic [CW-1:0] IN_CH,
    input  logic [AW-1:0] A,
    input  logic [BW-1:0] B,
    input  logic [BW-1:0] D,
    input  logic [PW-1:0] C,
    input  logic          USE_PRE,
    input  logic          PRE_SUB,
    input  logic [1:0]    ACC_MODE,
    input  logic          CIN,
    output logic          OUT_VALID,
    output logic [CW-1:0] OUT_CH,
    output logic [PW-1:0] P,
    output logic          OVF
);
    // Valid semantics: IN_VALID marks a sample at every CE-enabled edge, with no backpressure.
    // OUT_VALID stays set while CE is low; a result is consumed at an edge where CE is high.

    logic [AW-1:0] a1_q;
    logic [BW-1:0] b1_q, d1_q;
    logic [PW-1:0] c1_q;
    logic          use_pre1_q, pre_sub1_q, cin1_q, v1_q;
    logic [1:0]    mode1_q;
    logic [CW-1:0] ch1_q;

    logic [BW:0]   s2_d, s2_q, d_x, b_x;
    logic [AW-1:0] a2_q;
    logic [PW-1:0] c2_q;
    logic          cin2_q, v2_q;
    logic [1:0]    mode2_q;
    logic [CW-1:0] ch2_q;

    logic [AW+BW:0] a_x, s_x, prod;
    logic [PW-1:0]  m3_d, m3_q, c3_q;
    logic           cin3_q, v3_q;
    logic [1:0]     mode3_q;
    logic [CW-1:0]  ch3_q;

    logic [PW-1:0] base, p_d, p_q;
    logic [PW:0]   base_x, m_x, cin_x, r;
    logic          ovf_d, ovf_q, out_valid_q;
    logic [CW-1:0] out_ch_q;
    logic [PW-1:0] acc_q [NCH];

    always_comb begin
        d_x  = {d1_q[BW-1], d1_q};
        b_x  = {b1_q[BW-1], b1_q};
        s2_d = b_x;
        if (use_pre1_q) begin
            s2_d = pre_sub1_q ? (d_x - b_x) : (d_x + b_x);
        end
    end

    // Both operands are sign-extended to the full product width, so the truncated
    // unsigned product equals the signed product.
    always_comb begin
        a_x  = {{(BW+1){a2_q[AW-1]}}, a2_q};
        s_x  = {{AW{s2_q[BW]}}, s2_q};
        prod = a_x * s_x;
        m3_d = {{(PW-AW-BW-1){prod[AW+BW]}}, prod};
    end

    always_comb begin
        base = '0;
        case (mode3_q)
            2'b00:        base = c3_q;
            2'b01, 2'b10: base = acc_q[ch3_q];
            default:      base = '0;
        endcase
        base_x = {base[PW-1], base};
        m_x    = {m3_q[PW-1], m3_q};
        cin_x  = {{PW{1'b0}}, cin3_q};
        r      = (mode3_q == 2'b10) ? (base_x - m_x + cin_x) : (base_x + m_x + cin_x);
        ovf_d  = r[PW] ^ r[PW-1];
        p_d    = r[PW-1:0];
        if (ovf_d && (SAT != 0)) begin
            p_d = r[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a1_q <= '0; b1_q <= '0; d1_q <= '0; c1_q <= '0;
            use_pre1_q <= 1'b0; pre_sub1_q <= 1'b0; cin1_q <= 1'b0; v1_q <= 1'b0;
            mode1_q <= '0; ch1_q <= '0;
            s2_q <= '0; a2_q <= '0; c2_q <= '0; cin2_q <= 1'b0; v2_q <= 1'b0;
            mode2_q <= '0; ch2_q <= '0;
            m3_q <= '0; c3_q <= '0; cin3_q <= 1'b0; v3_q <= 1'b0;
            mode3_q <= '0; ch3_q <= '0;
            p_q <= '0; ovf_q <= 1'b0; out_valid_q <= 1'b0; out_ch_q <= '0;
        end else if (CE) begin
            a1_q <= A; b1_q <= B; d1_q <= D; c1_q <= C;
            use_pre1_q <= USE_PRE; pre_sub1_q <= PRE_SUB; cin1_q <= CIN; v1_q <= IN_VALID;
            mode1_q <= ACC_MODE; ch1_q <= IN_CH;
            s2_q <= s2_d; a2_q <= a1_q; c2_q <= c1_q; cin2_q <= cin1_q; v2_q <= v1_q;
            mode2_q <= mode1_q; ch2_q <= ch1_q;
            m3_q <= m3_d; c3_q <= c2_q; cin3_q <= cin2_q; v3_q <= v2_q;
            mode3_q <= mode2_q; ch3_q <= ch2_q;
            out_valid_q <= v3_q;
            if (v3_q) begin
                p_q      <= p_d;
                ovf_q    <= ovf_d;
                out_ch_q <= ch3_q;
            end
        end
    end

    // CLR acts regardless of CE and overrides a same-edge accumulator write.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NCH; i++) acc_q[i] <= '0;
        end else if (CLR) begin
            for (int i = 0; i < NCH; i++) acc_q[i] <= '0;
        end else if (CE && v3_q) begin
            acc_q[ch3_q] <= p_d;
        end
    end

    assign P         = p_q;
    assign OVF       = ovf_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_CH    = out_ch_q;
endmodule
